scan_ctrl: RTL and testbench
============================

SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 SHALL have parameter SUB_DIV, default 6250, meaning clk cycles per brightness sub-slot; each digit slot is 8 sub-slots (50 MHz -> 1 kHz per digit).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  scan run; low = display dark, counters held at 0.
REQ-005 SHALL have port din  input  32  eight BCD/hex nibbles; [31:28] = leftmost digit (sel 0).
REQ-006 SHALL have port din_valid  input  1  new frame data offered.
REQ-007 SHALL have port din_ready  output  1  pending buffer empty; transfer on din_valid & din_ready.
REQ-008 SHALL have port blank_mask  input  8  bit i high = digit sel i forced dark.
REQ-009 SHALL have port bright  input  3  on-time = bright+1 of 8 sub-slots per digit.
REQ-010 SHALL have port sel  output  3  current digit index, 0..7.
REQ-011 SHALL have port dig  output  8  active-low digit enable; sel n drives bit (7-n) low.
REQ-012 SHALL have port code  output  4  nibble of displayed frame for current sel.
REQ-013 SHALL have port frame_start  output  1  one-cycle pulse when sel wraps 7->0.

Function
REQ-014 SHALL run prescaler cnt 0..SUB_DIV-1; sub-tick when cnt==SUB_DIV-1, then cnt->0.
REQ-015 SHALL run sub-slot counter sub 0..7, advancing on each sub-tick.
REQ-016 SHALL advance sel by 1 on the sub-tick where sub==7, wrapping 7->0; frame_start high that same cycle only on the wrap.
REQ-017 SHALL hold a 32-bit shadow frame register; code = shadow nibble selected by sel (sel 0 -> [31:28], sel 7 -> [3:0]).
REQ-018 SHALL hold a one-deep pending register; din_ready = not pend_full; on accept, pend <= din, pend_full <= 1.
REQ-019 SHALL copy pend to shadow and clear pend_full on the cycle the wrap 7->0 occurs (frame boundary) if pend_full is set; shadow SHALL NOT change at any other time while enable high.
REQ-020 SHALL, on accept and frame boundary in the same cycle (pend_full was 0), load pend only; shadow updates at the following frame boundary.
REQ-021 SHALL, while din_valid is high and din_ready low, ignore din; no data loss of the already pending frame.
REQ-022 SHALL drive dig low on the sel bit only when enable high, sub <= bright and blank_mask[sel]==0; otherwise dig = 8'hFF.
REQ-023 SHALL keep sel, dig, code registered and mutually consistent every cycle (dig/code always describe the current sel, no one-cycle skew).
REQ-024 SHALL, while enable low: cnt=0, sub=0, sel=0, dig=8'hFF, frame_start=0; pending transfers to shadow the cycle after it is accepted.
REQ-025 SHALL, when enable rises, start scanning from sel 0, sub 0, cnt 0 in the next cycle.
REQ-026 SHALL sample bright and blank_mask every cycle (changes take effect on the next clock edge, no frame sync).

Reset
REQ-027 SHALL, on rst high at a clock edge: cnt=0, sub=0, sel=0, dig=8'hFF, code=4'h0, shadow=0, pend_full=0 (din_ready=1), frame_start=0.
REQ-028 SHALL let rst override enable, din_valid and any in-progress frame; pending data is discarded.

Verification (SUB_DIV=4, so slot = 32 cycles, frame = 256 cycles)
REQ-029 SHALL verify reset: assert rst 2 cycles -> dig=FF, sel=0, code=0, din_ready=1, frame_start=0.
REQ-030 SHALL verify scan: enable=1, bright=7, mask=00, load 32'h12345678 -> after first frame_start, sel 0..7 each 32 cycles with dig 7F,BF,DF,EF,F7,FB,FD,FE and code 1..8.
REQ-031 SHALL verify brightness: bright=1 -> dig low exactly 8 of every 32 cycles per digit (sub 0,1); bright=0 -> 4 cycles.
REQ-032 SHALL verify handshake: load 32'hAAAAAAAA mid-frame -> din_ready=0, code unchanged until frame_start, then A; second din_valid while full ignored; din_ready returns 1 the cycle after the boundary.
REQ-033 SHALL verify blanking: blank_mask=8'h01 -> dig stays FF throughout the sel 0 slot, other digits unaffected.
REQ-034 SHALL verify reset mid-operation: rst at sel=5 with pend_full=1 -> next cycle sel=0, dig=FF, din_ready=1, shadow=0.

Source files
------------

// File: rtl/scan_ctrl.sv
// Eight-digit multiplexed display scanner with per-digit PWM brightness and a
// double-buffered frame: new data waits in a pending slot until the next frame wrap.
module scan_ctrl #(
  parameter int SUB_DIV = 6250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [7:0]  blank_mask,
  input  logic [2:0]  bright,
  output logic [2:0]  sel,
  output logic [7:0]  dig,
  output logic [3:0]  code,
  output logic        frame_start
);

  localparam int CW = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SUB_DIV - 1);

  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    sub, sub_n, sel_n;
  logic [31:0]   shadow, shadow_n, pend;
  logic          pend_full, en_d, run, tick, wrap, accept, xfer;
  logic [7:0]    dig_n;
  logic [3:0]    code_n;

  assign din_ready = ~pend_full;
  assign accept    = din_valid & ~pend_full;
  // The first enabled cycle only restarts the counters at zero; counting begins after it.
  assign run       = enable & en_d;
  assign tick      = (cnt == CNT_MAX);
  assign wrap      = run & tick & (sub == 3'd7) & (sel == 3'd7);
  assign xfer      = pend_full & (wrap | ~enable);

  // Outputs are registered from next-state values so sel, dig and code never skew.
  always_comb begin
    cnt_n = '0;
    sub_n = '0;
    sel_n = '0;
    if (run) begin
      cnt_n = tick ? '0 : cnt + 1'b1;
      sub_n = tick ? sub + 3'd1 : sub;
      sel_n = (tick && sub == 3'd7) ? sel + 3'd1 : sel;
    end
    shadow_n = xfer ? pend : shadow;
    code_n   = shadow_n[{~sel_n, 2'b00} +: 4];
    dig_n    = 8'hFF;
    if (enable && (sub_n <= bright) && !blank_mask[sel_n])
      dig_n[~sel_n] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_d        <= 1'b0;
      cnt         <= '0;
      sub         <= '0;
      sel         <= '0;
      shadow      <= '0;
      pend        <= '0;
      pend_full   <= 1'b0;
      dig         <= 8'hFF;
      code        <= 4'h0;
      frame_start <= 1'b0;
    end else begin
      en_d        <= enable;
      cnt         <= cnt_n;
      sub         <= sub_n;
      sel         <= sel_n;
      shadow      <= shadow_n;
      dig         <= dig_n;
      code        <= code_n;
      frame_start <= enable && (cnt_n == CNT_MAX) && (sub_n == 3'd7) && (sel_n == 3'd7);
      if (accept) begin
        pend      <= din;
        pend_full <= 1'b1;
      end else if (xfer) begin
        pend_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scan_ctrl.sv
// Bench for scan_ctrl (SUB_DIV=4): directed scenarios plus random traffic, all
// outputs compared every cycle against a phase-arithmetic reference model.
module tb_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, enable, din_valid, din_ready, frame_start;
  logic [31:0] din;
  logic [7:0]  blank_mask, dig;
  logic [2:0]  bright, sel;
  logic [3:0]  code;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: display position is a phase count since scanning began.
  logic [31:0] m_shadow, m_pend;
  logic        m_pf, m_scan;
  logic [2:0]  m_bright;
  logic [7:0]  m_mask;
  int          phase;

  logic [7:0] dig_tab [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  always #5 clk = ~clk;

  scan_ctrl #(.SUB_DIV(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .blank_mask(blank_mask), .bright(bright), .sel(sel),
    .dig(dig), .code(code), .frame_start(frame_start)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic acc, wrap;
    if (rst) begin
      m_shadow = '0; m_pend = '0; m_pf = 1'b0; m_scan = 1'b0; phase = 0;
    end else begin
      acc  = din_valid && !m_pf;
      wrap = enable && m_scan && (phase % 256 == 255);
      if (m_pf && (wrap || !enable)) begin
        m_shadow = m_pend;
        m_pf     = 1'b0;
      end
      if (acc) begin
        m_pend = din;
        m_pf   = 1'b1;
      end
      if (!enable) begin
        m_scan = 1'b0;
        phase  = 0;
      end else if (!m_scan) begin
        m_scan = 1'b1;
        phase  = 0;
      end else begin
        phase++;
      end
    end
    m_bright = bright;
    m_mask   = blank_mask;
  endtask

  task automatic compare_all();
    int s, sb;
    logic [7:0]  e_dig;
    logic [31:0] tmp;
    s  = m_scan ? (phase / 32) % 8 : 0;
    sb = m_scan ? (phase / 4) % 8 : 0;
    e_dig = 8'hFF;
    if (m_scan && sb <= int'(m_bright) && !m_mask[s]) e_dig = ~(8'h80 >> s);
    tmp = m_shadow >> (4 * (7 - s));
    check("sel", sel, s);
    check("dig", dig, e_dig);
    check("code", code, tmp[3:0]);
    check("frame_start", frame_start, m_scan && (phase % 256 == 255));
    check("din_ready", din_ready, !m_pf);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Returns positioned on the cycle where frame_start is high.
  task automatic wait_fs();
    int n = 0;
    step();
    while (frame_start !== 1'b1 && n < 600) begin
      step();
      n++;
    end
    check("fs_timeout", n < 600, 1);
  endtask

  task automatic count_on(input int cycles, output int on);
    on = 0;
    for (int c = 0; c < cycles; c++) begin
      if (dig !== 8'hFF) on++;
      step();
    end
  endtask

  initial begin
    int on, n;
    rst = 1'b1; enable = 1'b0; din = '0; din_valid = 1'b0; blank_mask = 8'h00; bright = 3'd7;
    repeat (2) step();
    check("rst_dig", dig, 8'hFF);
    check("rst_sel", sel, 0);
    check("rst_code", code, 0);
    check("rst_ready", din_ready, 1);
    check("rst_fs", frame_start, 0);

    // Load while dark: goes straight through to the shadow register.
    rst = 1'b0; din = 32'h12345678; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    check("dark_xfer_ready", din_ready, 1);
    check("dark_xfer_code", code, 4'h1);

    enable = 1'b1;
    wait_fs();
    step();
    for (int c = 0; c < 256; c++) begin
      if (c % 32 == 16) begin
        check("scan_sel", sel, c / 32);
        check("scan_dig", dig, dig_tab[c / 32]);
        check("scan_code", code, c / 32 + 1);
      end
      step();
    end

    bright = 3'd1;
    wait_fs(); step();
    count_on(32, on);
    check("bright1_on", on, 8);
    bright = 3'd0;
    wait_fs(); step();
    count_on(32, on);
    check("bright0_on", on, 4);

    bright = 3'd7;
    wait_fs(); step();
    repeat (40) step();
    din = 32'hAAAAAAAA; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    check("hs_ready_low", din_ready, 0);
    check("hs_code_hold", code, 4'h2);
    din = 32'h55555555; din_valid = 1'b1;
    repeat (5) step();
    din_valid = 1'b0;
    wait_fs();
    check("hs_fs_code", code, 4'h8);
    check("hs_fs_ready", din_ready, 0);
    step();
    check("hs_new_code", code, 4'hA);
    check("hs_ready_back", din_ready, 1);
    wait_fs(); step();
    check("hs_no_overwrite", code, 4'hA);

    blank_mask = 8'h01;
    wait_fs(); step();
    count_on(32, on);
    check("blank_sel0_on", on, 0);
    count_on(32, on);
    check("blank_sel1_on", on, 32);

    for (int i = 0; i < 3000; i++) begin
      din_valid = ($urandom_range(0, 3) == 0);
      din       = $urandom;
      bright    = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 63) == 0) blank_mask = 8'($urandom);
      enable    = ($urandom_range(0, 499) != 0);
      step();
    end

    din_valid = 1'b0; enable = 1'b1; blank_mask = 8'h00; bright = 3'd7;
    n = 0;
    while (din_ready !== 1'b1 && n < 600) begin step(); n++; end
    check("rm_drain_timeout", n < 600, 1);
    n = 0;
    while (sel !== 3'd5 && n < 600) begin step(); n++; end
    check("rm_sel5_timeout", n < 600, 1);
    din = 32'hDEADBEEF; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    check("rm_pend_full", din_ready, 0);
    rst = 1'b1;
    step();
    check("rm_sel", sel, 0);
    check("rm_dig", dig, 8'hFF);
    check("rm_ready", din_ready, 1);
    check("rm_code", code, 0);
    rst = 1'b0;
    wait_fs(); step();
    check("rm_discarded", code, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
